// File: rtl/counter_tick_source.sv
// Tick source for the 8-bit display counter: programmable-rate divider in auto mode,
// debounced one-shot pushbutton in manual mode, plus the debounced key level for status.
module counter_tick_source #(
  parameter int unsigned      DIV_W           = 28,
  parameter logic [DIV_W-1:0] PERIOD_0        = '0,
  parameter logic [DIV_W-1:0] PERIOD_1        = DIV_W'(49_999_999),
  parameter logic [DIV_W-1:0] PERIOD_2        = DIV_W'(99_999_999),
  parameter logic [DIV_W-1:0] PERIOD_3        = DIV_W'(199_999_999),
  parameter int unsigned      DB_W            = 20,
  parameter int unsigned      DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             Clock,
  input  logic             Clear_b,
  input  logic             Enable,
  input  logic             Mode,
  input  logic [1:0]       Rate,
  input  logic             Key_b,
  output logic             Tick,
  output logic             Key_pressed,
  output logic [DIV_W-1:0] Count
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } db_state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       rate_q;
  logic [DIV_W-1:0] reload;
  logic             rate_change;
  logic             div_fire;
  logic             sync1;
  logic             sync2;
  logic             key_raw;
  db_state_t        state;
  db_state_t        next_state;
  logic [DB_W-1:0]  db_cnt;
  logic [DB_W-1:0]  db_next;
  logic             press_fire;

  always_comb begin
    reload = PERIOD_0;
    case (Rate)
      2'd0:    reload = PERIOD_0;
      2'd1:    reload = PERIOD_1;
      2'd2:    reload = PERIOD_2;
      default: reload = PERIOD_3;
    endcase
  end

  assign rate_change = (Rate != rate_q);
  assign div_fire    = !rate_change && !Mode && Enable && (Count == '0);

  // A rate change restarts the period before anything else; manual mode parks at reload.
  always_ff @(posedge Clock or negedge Clear_b) begin
    if (!Clear_b) begin
      rate_q <= 2'd0;
      Count  <= PERIOD_0;
    end else begin
      rate_q <= Rate;
      if (rate_change || Mode) begin
        Count <= reload;
      end else if (Enable) begin
        if (Count == '0) begin
          Count <= reload;
        end else begin
          Count <= Count - DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Clear_b) begin
    if (!Clear_b) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= Key_b;
      sync2 <= sync1;
    end
  end

  assign key_raw = ~sync2;

  always_ff @(posedge Clock or negedge Clear_b) begin
    if (!Clear_b) begin
      state  <= IDLE;
      db_cnt <= '0;
    end else begin
      state  <= next_state;
      db_cnt <= db_next;
    end
  end

  // Any state change restarts the stability count.
  always_comb begin
    next_state = state;
    db_next    = db_cnt;
    case (state)
      IDLE: begin
        if (key_raw) begin
          next_state = WAIT_PRESS;
          db_next    = '0;
        end
      end
      WAIT_PRESS: begin
        if (!key_raw) begin
          next_state = IDLE;
          db_next    = '0;
        end else if (db_cnt == DB_LAST) begin
          next_state = PRESSED;
          db_next    = '0;
        end else begin
          db_next = db_cnt + DB_W'(1);
        end
      end
      PRESSED: begin
        if (!key_raw) begin
          next_state = WAIT_RELEASE;
          db_next    = '0;
        end
      end
      default: begin
        if (key_raw) begin
          next_state = PRESSED;
          db_next    = '0;
        end else if (db_cnt == DB_LAST) begin
          next_state = IDLE;
          db_next    = '0;
        end else begin
          db_next = db_cnt + DB_W'(1);
        end
      end
    endcase
  end

  assign press_fire = (state == WAIT_PRESS) && (next_state == PRESSED) && Mode && Enable;

  always_ff @(posedge Clock or negedge Clear_b) begin
    if (!Clear_b) begin
      Tick        <= 1'b0;
      Key_pressed <= 1'b0;
    end else begin
      Tick        <= div_fire | press_fire;
      Key_pressed <= (next_state == PRESSED) || (next_state == WAIT_RELEASE);
    end
  end

endmodule

// File: tb/tb_counter_tick_source.sv
// Scoreboard bench for counter_tick_source with short periods (0,3,7,15) and a 4-cycle debounce.
module tb_counter_tick_source;

  typedef struct {
    logic [7:0] count;
    logic       tick;
  } exp_t;

  logic       Clock;
  logic       Clear_b;
  logic       Enable;
  logic       Mode;
  logic [1:0] Rate;
  logic       Key_b;
  logic       Tick;
  logic       Key_pressed;
  logic [7:0] Count;

  exp_t sb[$];
  int   tests_run;
  int   tests_failed;

  counter_tick_source #(
    .DIV_W(8),
    .PERIOD_0(8'd0),
    .PERIOD_1(8'd3),
    .PERIOD_2(8'd7),
    .PERIOD_3(8'd15),
    .DB_W(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .Clock(Clock),
    .Clear_b(Clear_b),
    .Enable(Enable),
    .Mode(Mode),
    .Rate(Rate),
    .Key_b(Key_b),
    .Tick(Tick),
    .Key_pressed(Key_pressed),
    .Count(Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic test_reset();
    Clear_b = 1'b0;
    Enable  = 1'b1;
    Mode    = 1'b0;
    Rate    = 2'd1;
    Key_b   = 1'b1;
    #2;
    tests_run += 3;
    if (Tick !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_tick got %b want 0", Tick);
    end
    if (Key_pressed !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_key got %b want 0", Key_pressed);
    end
    if (Count !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_count got %0d want 0", Count);
    end
    @(posedge Clock);
    #1;
    Clear_b = 1'b1;
  endtask

  task automatic test_auto_rate1();
    exp_t e;
    for (int k = 1; k <= 12; k++) begin
      sb.push_back('{count: 8'(3 - ((k - 1) % 4)), tick: ((k - 1) % 4 == 0) && (k > 1)});
      @(posedge Clock);
      #1;
      e = sb.pop_front();
      tests_run += 2;
      if (Count !== e.count) begin
        tests_failed++;
        $display("[TB] FAIL auto_count cycle %0d got %0d want %0d", k, Count, e.count);
      end
      if (Tick !== e.tick) begin
        tests_failed++;
        $display("[TB] FAIL auto_tick cycle %0d got %b want %b", k, Tick, e.tick);
      end
    end
  endtask

  task automatic test_rate0();
    exp_t e;
    Rate = 2'd0;
    sb.push_back('{count: 8'd0, tick: 1'b0});
    for (int k = 0; k < 8; k++) sb.push_back('{count: 8'd0, tick: 1'b1});
    while (sb.size() > 0) begin
      @(posedge Clock);
      #1;
      e = sb.pop_front();
      tests_run += 2;
      if (Count !== e.count) begin
        tests_failed++;
        $display("[TB] FAIL rate0_count got %0d want %0d", Count, e.count);
      end
      if (Tick !== e.tick) begin
        tests_failed++;
        $display("[TB] FAIL rate0_tick got %b want %b", Tick, e.tick);
      end
    end
  endtask

  task automatic test_rate_change();
    exp_t e;
    Rate = 2'd1;
    sb.push_back('{count: 8'd3, tick: 1'b0});
    sb.push_back('{count: 8'd2, tick: 1'b0});
    sb.push_back('{count: 8'd1, tick: 1'b0});
    while (sb.size() > 0) begin
      @(posedge Clock);
      #1;
      e = sb.pop_front();
      tests_run++;
      if (Count !== e.count || Tick !== e.tick) begin
        tests_failed++;
        $display("[TB] FAIL rc_setup got %0d/%b want %0d/%b", Count, Tick, e.count, e.tick);
      end
    end
    // Count is now 1: switching rate must reload without a Tick.
    Rate = 2'd3;
    sb.push_back('{count: 8'd15, tick: 1'b0});
    for (int v = 14; v >= 0; v--) sb.push_back('{count: 8'(v), tick: 1'b0});
    sb.push_back('{count: 8'd15, tick: 1'b1});
    while (sb.size() > 0) begin
      @(posedge Clock);
      #1;
      e = sb.pop_front();
      tests_run++;
      if (Count !== e.count || Tick !== e.tick) begin
        tests_failed++;
        $display("[TB] FAIL rate_change got %0d/%b want %0d/%b", Count, Tick, e.count, e.tick);
      end
    end
  endtask

  task automatic test_enable_pause();
    exp_t e;
    Rate = 2'd1;
    for (int c = 0; c < 15; c++) begin
      if (c < 2) e = '{count: 8'(3 - c), tick: 1'b0};
      else if (c < 12) e = '{count: 8'd2, tick: 1'b0};
      else if (c == 14) e = '{count: 8'd3, tick: 1'b1};
      else e = '{count: 8'(13 - c), tick: 1'b0};
      Enable = !(c >= 2 && c < 12);
      sb.push_back(e);
      @(posedge Clock);
      #1;
      e = sb.pop_front();
      tests_run++;
      if (Count !== e.count || Tick !== e.tick) begin
        tests_failed++;
        $display("[TB] FAIL enable_pause cycle %0d got %0d/%b want %0d/%b", c, Count, Tick, e.count, e.tick);
      end
    end
    Enable = 1'b1;
  endtask

  task automatic test_manual();
    exp_t e;
    Mode = 1'b1;
    for (int c = 0; c < 12; c++) begin
      Key_b = !(c < 3);
      sb.push_back('{count: 8'd3, tick: 1'b0});
      @(posedge Clock);
      #1;
      e = sb.pop_front();
      tests_run++;
      if (Count !== e.count || Tick !== e.tick) begin
        tests_failed++;
        $display("[TB] FAIL short_press cycle %0d got %0d/%b want %0d/%b", c, Count, Tick, e.count, e.tick);
      end
    end
    // Long press, then a 2-cycle bounce on release.
    for (int c = 0; c < 45; c++) begin
      Key_b = !(c < 20 || (c >= 22 && c < 24));
      sb.push_back('{count: 8'd3, tick: (c == 6)});
      @(posedge Clock);
      #1;
      e = sb.pop_front();
      tests_run++;
      if (Count !== e.count || Tick !== e.tick) begin
        tests_failed++;
        $display("[TB] FAIL long_press cycle %0d got %0d/%b want %0d/%b", c, Count, Tick, e.count, e.tick);
      end
      if (c == 9) begin
        tests_run++;
        if (Key_pressed !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL key_pressed_held got %b want 1", Key_pressed);
        end
      end
    end
    tests_run++;
    if (Key_pressed !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL key_released got %b want 0", Key_pressed);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      Key_b = 1'b0;
      @(posedge Clock);
      #1;
    end
    #2;
    Clear_b = 1'b0;
    #1;
    tests_run += 3;
    if (Tick !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_tick got %b want 0", Tick);
    end
    if (Key_pressed !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_key got %b want 0", Key_pressed);
    end
    if (Count !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_count got %0d want 0", Count);
    end
    @(posedge Clock);
    #1;
    Clear_b = 1'b1;
    for (int c = 0; c < 12; c++) begin
      sb.push_back('{count: 8'd3, tick: (c == 6)});
      @(posedge Clock);
      #1;
      e = sb.pop_front();
      tests_run++;
      if (Count !== e.count || Tick !== e.tick) begin
        tests_failed++;
        $display("[TB] FAIL post_reset_press cycle %0d got %0d/%b want %0d/%b", c, Count, Tick, e.count, e.tick);
      end
    end
    Key_b = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_auto_rate1();
    test_rate0();
    test_rate_change();
    test_enable_pause();
    test_manual();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
